// File: rtl/dual_da_pkg.sv
// Shared widths, config/state enums and the read tag for the dual-DA ROM scheduler.
// amp_scale is only referenced when DUAL_DA_AMP_SCALE_EN is defined.
package dual_da_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;
  localparam int ACC_W  = 32;
  localparam int AMP_W  = 8;

  typedef enum logic [1:0] {
    SEL_FTW  = 2'b00,
    SEL_POFS = 2'b01,
    SEL_CLR  = 2'b10,
    SEL_AMP  = 2'b11
  } cfg_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT_A = 2'd1,
    SLOT_B = 2'd2
  } state_e;

  typedef struct packed {
    logic vld;
    logic ch;
  } tag_t;

  // (sample * amp) >> 8, truncated back to the sample width
  function automatic logic [DATA_W-1:0] amp_scale(input logic [DATA_W-1:0] s,
                                                  input logic [AMP_W-1:0]  a);
    logic [DATA_W+AMP_W-1:0] prod;
    prod = {{AMP_W{1'b0}}, s} * {{DATA_W{1'b0}}, a};
    return prod[DATA_W+AMP_W-1 -: DATA_W];
  endfunction

endpackage

// File: rtl/dual_da_rom_scheduler_if.sv
// Config, ROM and DAC-side signals of the dual-DA ROM scheduler.
// slave = scheduler view, master = driver/ROM/DAC view.
interface dual_da_rom_scheduler_if;
  import dual_da_pkg::*;

  logic              run_en;
  logic              cfg_wr;
  logic              cfg_ch;
  logic [1:0]        cfg_sel;
  logic [ACC_W-1:0]  cfg_data;
  logic              cfg_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd_data;
  logic [DATA_W-1:0] da_a_data;
  logic              da_a_vld;
  logic [DATA_W-1:0] da_b_data;
  logic              da_b_vld;
  logic              busy;

  modport slave (
    input  run_en, cfg_wr, cfg_ch, cfg_sel, cfg_data, rom_rd_data,
    output cfg_ready, rom_addr, da_a_data, da_a_vld, da_b_data, da_b_vld, busy
  );

  modport master (
    output run_en, cfg_wr, cfg_ch, cfg_sel, cfg_data, rom_rd_data,
    input  cfg_ready, rom_addr, da_a_data, da_a_vld, da_b_data, da_b_vld, busy
  );

endinterface

// File: rtl/dual_da_phase_acc.sv
// One channel's phase accumulator with FTW, phase offset and clear; phase_o is the
// registered acc + offset, so a same-cycle apply only affects the accumulate.
module dual_da_phase_acc
  import dual_da_pkg::*;
(
  input  logic              clk_tb,
  input  logic              tb_rst,
  input  logic              issue_i,
  input  logic              apply_i,
  input  cfg_sel_e          sel_i,
  input  logic [ACC_W-1:0]  data_i,
  output logic [ADDR_W-1:0] phase_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W-1:0] pofs_q, pofs_d;
  logic [ACC_W-ADDR_W-1:0] phase_lo_unused;

  always_comb begin
    ftw_d  = ftw_q;
    pofs_d = pofs_q;
    acc_d  = acc_q;
    if (apply_i && sel_i == SEL_FTW)  ftw_d  = data_i;
    if (apply_i && sel_i == SEL_POFS) pofs_d = data_i;
    if (apply_i && sel_i == SEL_CLR)  acc_d  = '0;
    else if (issue_i)                 acc_d  = acc_q + ftw_d;
  end

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      acc_q  <= '0;
      ftw_q  <= '0;
      pofs_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ftw_q  <= ftw_d;
      pofs_q <= pofs_d;
    end
  end

  assign {phase_o, phase_lo_unused} = acc_q + pofs_q;

endmodule

// File: rtl/dual_da_rom_scheduler.sv
// Shares one waveform ROM between DAC channels A and B in alternating A/B slots.
// Optional DUAL_DA_AMP_SCALE_EN adds per-channel 8-bit amplitude scaling (+1 cycle).
module dual_da_rom_scheduler
  import dual_da_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input logic                    clk_tb,
  input logic                    tb_rst,
  dual_da_rom_scheduler_if.slave bus
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              sh_ch_q;
  cfg_sel_e          sh_sel_q;
  logic [ACC_W-1:0]  sh_data_q;
  logic              sel_ok, accept, apply;
  logic              issue_a, issue_b;
  logic [ADDR_W-1:0] phase_a, phase_b;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  tag_t              iss_q, iss_d;
  tag_t              pipe_q [ROM_LAT];
  tag_t              cap_tag;
  logic [DATA_W-1:0] cap_dat;
  logic [DATA_W-1:0] da_a_q, da_b_q;
  logic              da_a_vld_q, da_b_vld_q;
  logic              pipe_busy;

  always_comb begin
    state_d    = state_q;
    issue_a    = 1'b0;
    issue_b    = 1'b0;
    rom_addr_d = rom_addr_q;
    case (state_q)
      IDLE:    if (bus.run_en) state_d = SLOT_A;
      SLOT_A: begin
        state_d    = SLOT_B;
        issue_a    = 1'b1;
        rom_addr_d = phase_a;
      end
      SLOT_B: begin
        state_d    = bus.run_en ? SLOT_A : IDLE;
        issue_b    = 1'b1;
        rom_addr_d = phase_b;
      end
      default: state_d = IDLE;
    endcase
    iss_d.vld = issue_a | issue_b;
    iss_d.ch  = issue_b;
  end

`ifdef DUAL_DA_AMP_SCALE_EN
  assign sel_ok = 1'b1;
`else
  assign sel_ok = (cfg_sel_e'(bus.cfg_sel) != SEL_AMP);
`endif

  // Shadow applies at a pair boundary (SLOT_A) or straight away when idle.
  assign accept = bus.cfg_wr & ~pend_q & sel_ok;
  assign apply  = pend_q & (state_q != SLOT_B);
  assign pend_d = accept | (pend_q & ~apply);

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      pend_q    <= 1'b0;
      sh_ch_q   <= 1'b0;
      sh_sel_q  <= SEL_FTW;
      sh_data_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        sh_ch_q   <= bus.cfg_ch;
        sh_sel_q  <= cfg_sel_e'(bus.cfg_sel);
        sh_data_q <= bus.cfg_data;
      end
    end
  end

  dual_da_phase_acc u_acc_a (
    .clk_tb  (clk_tb),
    .tb_rst  (tb_rst),
    .issue_i (issue_a),
    .apply_i (apply & ~sh_ch_q),
    .sel_i   (sh_sel_q),
    .data_i  (sh_data_q),
    .phase_o (phase_a)
  );

  dual_da_phase_acc u_acc_b (
    .clk_tb  (clk_tb),
    .tb_rst  (tb_rst),
    .issue_i (issue_b),
    .apply_i (apply & sh_ch_q),
    .sel_i   (sh_sel_q),
    .data_i  (sh_data_q),
    .phase_o (phase_b)
  );

  // iss_q travels with rom_addr; the tag pipe then mirrors the ROM latency.
  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      iss_q      <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      iss_q      <= iss_d;
      pipe_q[0]  <= iss_q;
      for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef DUAL_DA_AMP_SCALE_EN
  logic [AMP_W-1:0]  amp_a_q, amp_b_q;
  tag_t              sc_tag_q;
  logic [DATA_W-1:0] sc_dat_q;

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      amp_a_q  <= '1;
      amp_b_q  <= '1;
      sc_tag_q <= '0;
      sc_dat_q <= '0;
    end else begin
      if (apply && sh_sel_q == SEL_AMP) begin
        if (sh_ch_q) amp_b_q <= sh_data_q[AMP_W-1:0];
        else         amp_a_q <= sh_data_q[AMP_W-1:0];
      end
      sc_tag_q <= pipe_q[ROM_LAT-1];
      sc_dat_q <= amp_scale(bus.rom_rd_data, pipe_q[ROM_LAT-1].ch ? amp_b_q : amp_a_q);
    end
  end

  assign cap_tag = sc_tag_q;
  assign cap_dat = sc_dat_q;
`else
  assign cap_tag = pipe_q[ROM_LAT-1];
  assign cap_dat = bus.rom_rd_data;
`endif

  always_ff @(posedge clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      da_a_q     <= '0;
      da_b_q     <= '0;
      da_a_vld_q <= 1'b0;
      da_b_vld_q <= 1'b0;
    end else begin
      da_a_vld_q <= cap_tag.vld & ~cap_tag.ch;
      da_b_vld_q <= cap_tag.vld &  cap_tag.ch;
      if (cap_tag.vld & ~cap_tag.ch) da_a_q <= cap_dat;
      if (cap_tag.vld &  cap_tag.ch) da_b_q <= cap_dat;
    end
  end

  // The strobe cycle still counts as busy so busy drops after the last strobe.
  always_comb begin
    pipe_busy = iss_q.vld | cap_tag.vld | da_a_vld_q | da_b_vld_q;
    for (int i = 0; i < ROM_LAT; i++) pipe_busy = pipe_busy | pipe_q[i].vld;
  end

  assign bus.busy      = (state_q != IDLE) | pipe_busy;
  assign bus.cfg_ready = ~pend_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.da_a_data = da_a_q;
  assign bus.da_a_vld  = da_a_vld_q;
  assign bus.da_b_data = da_b_q;
  assign bus.da_b_vld  = da_b_vld_q;

endmodule

// File: tb/tb_dual_da_rom_scheduler.sv
// Bench for dual_da_rom_scheduler: identity ROM with ROM_LAT latency, directed scenarios
// plus random run/config traffic, checked every cycle against a slot-level phase model.
module tb_dual_da_rom_scheduler;
  import dual_da_pkg::*;

  localparam int ROM_LAT = 1;
`ifdef DUAL_DA_AMP_SCALE_EN
  localparam int AMP_EN = 1;
`else
  localparam int AMP_EN = 0;
`endif

  logic clk_tb = 1'b0;
  logic tb_rst = 1'b1;
  always #5 clk_tb = ~clk_tb;

  dual_da_rom_scheduler_if bus();

  dual_da_rom_scheduler #(.ROM_LAT(ROM_LAT)) dut (
    .clk_tb (clk_tb),
    .tb_rst (tb_rst),
    .bus    (bus)
  );

  // Identity ROM: data = address, ROM_LAT cycles after the address is presented.
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk_tb) begin
    rom_pipe[0] <= bus.rom_addr;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_rd_data = rom_pipe[ROM_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        drv_rst  = 1'b1;
  logic        drv_run  = 1'b0;
  logic        drv_wr   = 1'b0;
  logic        drv_ch   = 1'b0;
  logic [1:0]  drv_sel  = 2'b00;
  logic [31:0] drv_data = '0;

  // Reference model state: slot 0 idle, 1 A, 2 B (slot occupied in the current cycle).
  int          m_slot;
  logic [31:0] m_acc [2];
  logic [31:0] m_ftw [2];
  logic [31:0] m_pofs[2];
  logic [7:0]  m_amp [2];
  bit          m_pend;
  int          m_sh_ch;
  int          m_sh_sel;
  logic [31:0] m_sh_data;
  int          m_addr;
  int          hold_a, hold_b;
  int          max_due;
  int          exp_a[int];
  int          exp_b[int];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int scale(input int a, input logic [7:0] g);
    if (AMP_EN != 0) return (a * int'(g)) >> 8;
    return a;
  endfunction

  task automatic model_reset();
    m_slot = 0;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = '0; m_ftw[c] = '0; m_pofs[c] = '0; m_amp[c] = 8'hFF;
    end
    m_pend = 0; m_sh_ch = 0; m_sh_sel = 0; m_sh_data = '0;
    m_addr = 0; hold_a = 0; hold_b = 0; max_due = -1;
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic model_step();
    logic [31:0] ph;
    int ch, due;
    bit clr[2];
    bit apply_now;
    if (drv_rst) begin
      model_reset();
      return;
    end
    ch = (m_slot == 2) ? 1 : 0;
    if (m_slot != 0) begin
      ph     = m_acc[ch] + m_pofs[ch];
      m_addr = int'(ph[31:22]);
      due    = cyc + ROM_LAT + 2 + AMP_EN;
      if (ch == 0) exp_a[due] = scale(m_addr, m_amp[0]);
      else         exp_b[due] = scale(m_addr, m_amp[1]);
      max_due = due;
    end
    clr = '{0, 0};
    apply_now = m_pend && (m_slot != 2);
    if (apply_now) begin
      case (m_sh_sel)
        0: m_ftw[m_sh_ch]  = m_sh_data;
        1: m_pofs[m_sh_ch] = m_sh_data;
        2: clr[m_sh_ch]    = 1;
        default: m_amp[m_sh_ch] = m_sh_data[7:0];
      endcase
    end
    if (m_slot != 0) m_acc[ch] = m_acc[ch] + m_ftw[ch];
    for (int c = 0; c < 2; c++) if (clr[c]) m_acc[c] = '0;
    if (m_pend) begin
      if (apply_now) m_pend = 0;
    end else if (drv_wr && (AMP_EN != 0 || drv_sel != 2'b11)) begin
      m_pend = 1; m_sh_ch = int'(drv_ch); m_sh_sel = int'(drv_sel); m_sh_data = drv_data;
    end
    if (m_slot == 1) m_slot = 2;
    else             m_slot = drv_run ? 1 : 0;
  endtask

  task automatic check_cycle();
    bit ea, eb;
    ea = exp_a.exists(cyc);
    eb = exp_b.exists(cyc);
    if (ea) begin hold_a = exp_a[cyc]; exp_a.delete(cyc); end
    if (eb) begin hold_b = exp_b[cyc]; exp_b.delete(cyc); end
    check_eq("da_a_vld",  bus.da_a_vld,  32'(ea));
    check_eq("da_a_data", bus.da_a_data, hold_a);
    check_eq("da_b_vld",  bus.da_b_vld,  32'(eb));
    check_eq("da_b_data", bus.da_b_data, hold_b);
    check_eq("cfg_ready", bus.cfg_ready, 32'(!m_pend));
    check_eq("busy",      bus.busy,      32'((m_slot != 0) || (max_due >= cyc)));
    check_eq("rom_addr",  bus.rom_addr,  m_addr);
  endtask

  // One clock: check this cycle's outputs, drive this cycle's inputs, advance the model.
  task automatic step();
    @(negedge clk_tb);
    check_cycle();
    tb_rst       = drv_rst;
    bus.run_en   = drv_run;
    bus.cfg_wr   = drv_wr;
    bus.cfg_ch   = drv_ch;
    bus.cfg_sel  = drv_sel;
    bus.cfg_data = drv_data;
    model_step();
    cyc++;
    drv_wr = 1'b0;
  endtask

  task automatic cfg_write(input logic ch, input logic [1:0] sel, input logic [31:0] data);
    int guard;
    guard = 0;
    while (m_pend && guard < 40) begin
      step();
      guard++;
    end
    check_eq("cfg_wait_bound", 32'(guard < 40), 32'd1);
    drv_wr = 1'b1; drv_ch = ch; drv_sel = sel; drv_data = data;
    step();
  endtask

  task automatic stop_in_slot_a();
    int guard;
    guard = 0;
    while (m_slot != 1 && guard < 4) begin
      step();
      guard++;
    end
    drv_run = 1'b0;
    step();
  endtask

  initial begin
    bus.run_en = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_ch = 1'b0;
    bus.cfg_sel = 2'b00; bus.cfg_data = '0;
    model_reset();
    repeat (3) step();
    drv_rst = 1'b0;
    repeat (2) step();
`ifdef DUAL_DA_AMP_SCALE_EN
    cfg_write(1'b0, 2'b11, 32'h80);
    cfg_write(1'b1, 2'b11, 32'h80);
`endif
    // Equal FTWs, zero offsets: both channels count 0,1,2,...
    cfg_write(1'b0, 2'b00, 32'h0040_0000);
    cfg_write(1'b1, 2'b00, 32'h0040_0000);
    drv_run = 1'b1;
    repeat (40) step();
    // Stop in SLOT_A: the pair completes, then drain.
    stop_in_slot_a();
    repeat (12) step();
    // B half a turn ahead; run long enough for B to wrap 1023 -> 0.
    cfg_write(1'b0, 2'b10, 32'h0);
    cfg_write(1'b1, 2'b10, 32'h0);
    cfg_write(1'b1, 2'b01, 32'h8000_0000);
    drv_run = 1'b1;
    repeat (1060) step();
    // FTW change mid-run, second write while the first is pending is dropped.
    cfg_write(1'b0, 2'b00, 32'h0080_0000);
    drv_wr = 1'b1; drv_ch = 1'b0; drv_sel = 2'b00; drv_data = 32'h0100_0000;
    step();
    repeat (20) step();
    // Clear A while running.
    cfg_write(1'b0, 2'b10, 32'h0);
    repeat (20) step();
    // Reset with reads in flight; nothing must strobe afterwards until run_en returns.
    drv_rst = 1'b1;
    step();
    step();
    drv_rst = 1'b0; drv_run = 1'b0;
    repeat (10) step();
    cfg_write(1'b0, 2'b00, 32'h0040_0000);
    cfg_write(1'b1, 2'b00, 32'h0123_4567);
    drv_run = 1'b1;
    repeat (20) step();
    // Random run/stop and configuration traffic.
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) drv_run = ~drv_run;
      if ($urandom_range(0, 5) == 0) begin
        drv_wr   = 1'b1;
        drv_ch   = 1'($urandom_range(0, 1));
        drv_sel  = 2'($urandom_range(0, (AMP_EN != 0) ? 2 : 3));
        drv_data = $urandom;
      end
      step();
    end
    drv_run = 1'b0;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
